// File: rtl/u_if_prefetch.sv
// u_if_prefetch: prefetching instruction fetch stage.
// Pulls 32-bit words from instruction memory into a DEPTH-word queue
// and hands one instruction per cycle to decode, with stall and redirect.
// Optional macro U_IF_RVC_EN: when defined, 16-bit compressed instructions
// are realigned across word boundaries. When undefined, every instruction
// is one 32-bit word and the halfword aligner is not built.
module u_if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            mem_req_o,
  output logic [XLEN-3:0] mem_addr_o,
  input  logic            mem_busywait_i,
  input  logic [31:0]     mem_rdata_i,
  input  logic            stall_i,
  input  logic            branching_i,
  input  logic [XLEN-2:0] branch_pc_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic            is_long_o,
  output logic [XLEN-2:0] pc_o
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [XLEN-3:0] FA_ONE = {{(XLEN-3){1'b0}}, 1'b1};

`ifdef U_IF_RVC_EN
  localparam logic            RESET_OFF = RESET_PC[1];
  localparam logic [XLEN-2:0] RESET_HPC = RESET_PC[XLEN-1:1];
  localparam logic [CW-1:0]   CNT_TWO   = CW'(2'd2);
`else
  localparam logic [XLEN-2:0] RESET_HPC = {RESET_PC[XLEN-1:2], 1'b0};
`endif

  logic [31:0]     queue_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-3:0] fetch_addr_r;
  logic [XLEN-2:0] pc_r;
  logic            run_r;

  logic [31:0]     word0_s;
  logic [31:0]     instr_s;
  logic            long_s;
  logic            avail_s;
  logic            consume_s;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-2:0] pc_step_s;

  // A word is taken whenever a request meets a ready memory; a redirect
  // in the same cycle throws it away.
  assign mem_req_o  = run_r && (count_r < FULL_CNT);
  assign push_s     = mem_req_o && !mem_busywait_i;
  assign mem_addr_o = fetch_addr_r;
  assign pc_o       = pc_r;
  assign word0_s    = queue_r[rd_ptr_r];
  assign consume_s  = avail_s && !stall_i && !branching_i;

  assign instr_valid_o = avail_s;
  assign instr_o       = avail_s ? instr_s : 32'h0000_0000;

`ifdef U_IF_RVC_EN
  logic            off_r;
  logic            off_nxt_s;
  logic [PW-1:0]   rd_nxt_s;
  logic [31:0]     word1_s;
  logic [15:0]     head_half_s;

  assign rd_nxt_s  = rd_ptr_r + PTR_ONE;
  assign word1_s   = queue_r[rd_nxt_s];
  assign is_long_o = avail_s && long_s;

  // Realign the queue head into one compressed or long instruction
  always_comb begin
    head_half_s = off_r ? word0_s[31:16] : word0_s[15:0];
    long_s      = (head_half_s[1:0] == 2'b11);
    instr_s     = 32'h0000_0000;
    avail_s     = 1'b0;
    if (count_r == {CW{1'b0}}) begin
      avail_s = 1'b0;
    end else if (!long_s) begin
      avail_s = 1'b1;
      instr_s = {16'h0000, head_half_s};
    end else if (!off_r) begin
      avail_s = 1'b1;
      instr_s = word0_s;
    end else if (count_r >= CNT_TWO) begin
      avail_s = 1'b1;
      instr_s = {word1_s[15:0], word0_s[31:16]};
    end else begin
      avail_s = 1'b0;
    end
  end

  // Halfword advance of a consume: a word is released when the
  // instruction ends on or crosses its upper half
  always_comb begin
    pc_step_s = {{(XLEN-3){1'b0}}, long_s, ~long_s};
    pop_s     = 1'b0;
    off_nxt_s = off_r;
    if (consume_s) begin
      pop_s     = long_s | off_r;
      off_nxt_s = long_s ? off_r : ~off_r;
    end else begin
      pop_s     = 1'b0;
      off_nxt_s = off_r;
    end
  end

  // Halfword offset into the head word
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      off_r <= RESET_OFF;
    end else if (branching_i) begin
      off_r <= branch_pc_i[0];
    end else begin
      off_r <= off_nxt_s;
    end
  end
`else
  logic unused_branch_half_s;

  assign unused_branch_half_s = branch_pc_i[0];
  assign is_long_o            = run_r;

  // Whole-word instructions: the head word is the instruction
  always_comb begin
    long_s    = 1'b1;
    instr_s   = word0_s;
    avail_s   = (count_r != {CW{1'b0}});
    pop_s     = consume_s;
    pc_step_s = {{(XLEN-3){1'b0}}, 2'b10};
  end
`endif

  // Queue storage; only entries covered by count_r are meaningful
  always_ff @(posedge clk_i) begin
    if (push_s && !branching_i) begin
      queue_r[wr_ptr_r] <= mem_rdata_i;
    end
  end

  // Queue pointers, occupancy, fetch address, pc and run flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_r        <= 1'b0;
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      fetch_addr_r <= RESET_PC[XLEN-1:2];
      pc_r         <= RESET_HPC;
    end else if (branching_i) begin
      run_r        <= 1'b1;
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      fetch_addr_r <= branch_pc_i[XLEN-2:1];
`ifdef U_IF_RVC_EN
      pc_r         <= branch_pc_i;
`else
      pc_r         <= {branch_pc_i[XLEN-2:1], 1'b0};
`endif
    end else begin
      run_r <= 1'b1;
      if (push_s) begin
        wr_ptr_r     <= wr_ptr_r + PTR_ONE;
        fetch_addr_r <= fetch_addr_r + FA_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
      if (consume_s) begin
        pc_r <= pc_r + pc_step_s;
      end
    end
  end

endmodule

// File: doc/u_if_prefetch.md
Name: u_if_prefetch

Overview:
- Parametrised successor to the single-instruction fetch stage.
- Fetches 32-bit words from instruction memory/cache through a busywait handshake into a DEPTH-word prefetch queue.
- Realigns 16-bit (compressed) and 32-bit instructions across word boundaries and presents one instruction per cycle to decode, with stall and branch redirect.
- Sits between the instruction cache and the decode stage.

Parameters:
XLEN, 32, address width in bits
DEPTH, 4, prefetch queue depth in 32-bit words; power of two, >= 2
RESET_PC, 0, byte address fetched after reset; bit 0 must be 0

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
mem_req_o  output  1  fetch request
mem_addr_o  output  XLEN-2  word address [XLEN-1:2] of the requested word
mem_busywait_i  input  1  memory not ready; a word is accepted in any cycle with mem_req_o=1 and mem_busywait_i=0
mem_rdata_i  input  32  fetched word, valid in the accept cycle
stall_i  input  1  decode cannot take an instruction this cycle
branching_i  input  1  redirect fetch to branch_pc_i
branch_pc_i  input  XLEN-1  halfword target address [XLEN-1:1]
instr_valid_o  output  1  instr_o, is_long_o and pc_o are valid
instr_o  output  32  instruction; upper 16 bits are 0 when compressed
is_long_o  output  1  1 = 32-bit instruction (low half bits [1:0] == 2'b11)
pc_o  output  XLEN-1  halfword address [XLEN-1:1] of instr_o

Behaviour:
- State: word queue (rd/wr pointers and count 0..DEPTH), halfword offset off (0/1) into the head word, fetch_addr (word address) and pc.
- Reset (rst_i low, asynchronous):
  - Queue empty, off = RESET_PC[1], fetch_addr = RESET_PC[XLEN-1:2], pc = RESET_PC[XLEN-1:1].
  - Run flag cleared. Outputs: mem_req_o=0, instr_valid_o=0, instr_o=0, is_long_o=0, pc_o=RESET_PC[XLEN-1:1], mem_addr_o=RESET_PC[XLEN-1:2].
  - Run flag sets on the first rising edge after release.
- Request:
  - mem_req_o = run && count<DEPTH, evaluated on registered count; no pop bypass.
  - mem_addr_o = fetch_addr, registered.
  - On accept: push mem_rdata_i, then fetch_addr+1, wrapping mod 2^(XLEN-2).
  - mem_addr_o is held while busywait is high, except on redirect.
- Aligner (combinational from the queue):
  - off=0: head half = word0[15:0]. Long instruction = word0. Valid if count>=1.
  - off=1: head half = word0[31:16]. Compressed valid if count>=1. Long = {word1[15:0], word0[31:16]}, valid only if count>=2.
- Consume (instr_valid_o && !stall_i && !branching_i):
  - pc advances by 1 (compressed) or 2 (long), wrapping mod 2^(XLEN-1).
  - off and the pop count follow the halfword advance: 0 or 1 word popped per cycle; off toggles on compressed only.
  - Push and pop may occur in the same cycle; count is updated by the net change.
- Stall: outputs are held stable and the queue keeps filling until full. Full means mem_req_o=0, with no word lost or duplicated.
- Redirect (branching_i=1 at an edge):
  - Queue is emptied, any word accepted in that cycle is discarded, and the consume in that cycle is ignored.
  - fetch_addr = branch_pc_i[XLEN-1:2], off = branch_pc_i[1], pc = branch_pc_i.
  - instr_valid_o=0 in the next cycle; latency to the first valid output is 1 cycle after the first accept.
  - A branch to an odd halfword drops the low half of the first word.
  - Redirect takes priority over stall and consume.
- Latency: zero-wait memory gives instr_valid_o one cycle after the word is accepted.
- Queue contents are not reset-cleared beyond the output gating. instr_o is forced to 0 whenever instr_valid_o=0.

Optional Feature:
U_IF_RVC_EN
- Defined: compressed support as described above.
- Undefined:
  - All instructions are 32-bit: off is fixed 0, branch_pc_i[1] and RESET_PC[1] are ignored.
  - is_long_o is tied 1 (0 during reset), instr_o = word0, valid if count>=1.
  - Each consume pops one word and advances pc by 2.
  - The aligner logic is removed.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning 0x00000013 per word, stall_i=0 -> mem_req_o=1 one edge after release; pc_o 0x0,0x2,0x4 (bytes 0,4,8); is_long_o=1 throughout.
- Mixed stream, word@0=0x00130001, word@4=0x00010000 -> pc bytes 0/2/6 give instr 0x00000001 (compressed), 0x00000013 (long, spanning), 0x00000001 (compressed).
- branching_i pulse with branch_pc_i=0x81 (byte 0x102) -> next cycle instr_valid_o=0, mem_addr_o=0x40; first valid pc_o=0x81 from the high half of word 0x100.
- stall_i held 8 cycles, DEPTH=4 -> count reaches 4, mem_req_o=0, instr_o/pc_o stable; on release, consecutive pcs with no gap or duplicate.
- mem_busywait_i high 3 cycles -> mem_addr_o stable, instr_valid_o=0 once the queue drains. Branch during busywait -> response for the old address discarded; next accept is at the new word address.
- rst_i asserted mid-stream -> outputs go to reset values immediately; after release, fetch restarts at RESET_PC.
- Build without U_IF_RVC_EN -> word 0x00130001 output as one 32-bit instruction; pc advances by 2 (4 bytes).
